cipher_rounds: RTL and testbench
================================

# cipher_rounds

Iterative AES-128 encryption datapath, one round per clock. It consumes the round key produced each cycle by the key expansion stage (`keyexpansion`) and returns `done` to that stage so it freezes on the final round key. The block and key expansion share `clk`/`reset`, so one reset starts both in lockstep and yields the ciphertext 11 cycles later.

## Interface
- No parameters. AES-128 only; round count comes from the shared package.
- `clk`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high; also the start strobe
- `plaintext`  in  128  input block; sampled on every edge where `reset` is high
- `roundKey`  in  128  current round key from key expansion; word 0 is `[127:96]`
- `ciphertext`  out  128  state register; valid only while `done`=1
- `done`  out  1  encryption complete; drives key expansion `done`

## Operation
- Byte order follows FIPS-197 column-major:
  - `[127:120]` = s(0,0), `[119:112]` = s(1,0), … `[7:0]` = s(3,3).
  - Matches the key-word order from key expansion.
- Registers:
  - `state` (128): `ciphertext` = `state`.
  - `round` (4): range 0..10.
  - FSM: INIT, ROUND, FINAL, DONE.
- On `reset`:
  - `state` <= `plaintext`, `round` <= 0, FSM <= INIT, `done` <= 0.
- INIT (`roundKey` = round-0 key, i.e. the cipher key):
  - `state` <= `state` ^ `roundKey`; `round` <= 1; go to ROUND.
- ROUND (`round` 1..9):
  - `state` <= MixColumns(ShiftRows(SubBytes(`state`))) ^ `roundKey`; `round` += 1.
  - Go to FINAL when the pre-increment `round` = 9.
- FINAL (`round` 10):
  - `state` <= ShiftRows(SubBytes(`state`)) ^ `roundKey`; go to DONE; `done` <= 1.
- DONE:
  - `state`, `round` and `done` hold until the next `reset`.
  - `roundKey` is ignored.
- Illegal FSM encoding: go to DONE with `done`=0. Only `reset` recovers.
- Reset mid-operation (any state): aborts immediately with no partial output. New `plaintext` is captured and `done` clears on that edge.
- `plaintext` is don't-care whenever `reset` is low.
- All arithmetic is GF(2^8) with polynomial 0x11B. xtime = shift left, then XOR 0x1B if bit 7 was set.

## Timing
- Reset values:
  - `done` = 0.
  - `ciphertext` = `plaintext` sampled at the reset edge.
- Edge E0 is the last edge with `reset` high. The cycle after E_k carries round-k key, k = 0..10.
- Edge E1 completes INIT. Edges E2..E10 complete rounds 1..9. Edge E11 completes round 10.
- Latency: `done` rises after E11, 11 cycles after reset deasserts. `ciphertext` is valid in the same cycle.
- `done` is registered, with no combinational path from any input.
- Key expansion sees `done`=1 from E11 onward and holds its last key. This is harmless because DONE ignores `roundKey`.
- Critical path, one cycle: SubBytes → ShiftRows → MixColumns → XOR.

## Structure
- Shared package `aes_pkg` holds:
  - `NR` = 10.
  - The FSM enum `cipher_state_t`.
  - The S-box lookup function, so `subword` and this block share one table.
  - `xtime` as a function.
- SubBytes reuses the existing `subword` module ×4.
- ShiftRows is pure wiring in the top module.
- One new sub-module: `mixcolumn`, which takes a 32-bit column and returns a 32-bit column. It is instantiated ×4.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, driven through a real `keyexpansion`.
  - After E1, `state` = 193de3bea0f4e22b9ac68d2ae9f84808.
  - After E11, `done`=1 and `ciphertext` = 3925841d02dc09fbdc118597196a0b32.
  - `done`=0 on every earlier cycle.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a after E11.
- All-zero key and pt → 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Hold: after `done`, run 20 more cycles with `plaintext` randomised → `ciphertext` and `done` unchanged.
- Reset mid-run: start App. B, pulse `reset` after E5 with App. C.1 inputs.
  - `done`=0 on the reset edge.
  - App. C.1 ciphertext appears exactly 11 cycles after the new deassertion.
- Back-to-back: reset immediately after `done`, then App. B again → identical result and latency.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, cipher FSM encoding, S-box table
// and GF(2^8) doubling used by the key schedule and the cipher datapath.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } cipher_state_t;

    // Entry 0 sits in the top byte so the table reads in FIPS-197 order.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[8 * (255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/keyexpansion.sv
// AES-128 key schedule, one round key per clock; reset loads the cipher key
// and done_i freezes the current round key.
module keyexpansion
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_i,
    input  logic         done_i,
    output logic [127:0] round_key_o
);

    logic [127:0] rk_q, rk_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [31:0]  rot_word, sub_word, temp;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;

    assign rot_word = {rk_q[23:0], rk_q[31:24]};

    subword u_subword (
        .word_i (rot_word),
        .word_o (sub_word)
    );

    assign temp = sub_word ^ {rcon_q, 24'h0};
    assign w0_n = rk_q[127:96] ^ temp;
    assign w1_n = rk_q[95:64]  ^ w0_n;
    assign w2_n = rk_q[63:32]  ^ w1_n;
    assign w3_n = rk_q[31:0]   ^ w2_n;

    always_comb begin
        rk_d   = rk_q;
        rcon_d = rcon_q;
        if (!done_i) begin
            rk_d   = {w0_n, w1_n, w2_n, w3_n};
            rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rk_q   <= key_i;
            rcon_q <= 8'h01;
        end else begin
            rk_q   <= rk_d;
            rcon_q <= rcon_d;
        end
    end

    assign round_key_o = rk_q;

endmodule

// File: rtl/mixcolumn.sv
// MixColumns on a single column; byte 0 (row 0) is [31:24].
module mixcolumn
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    // Multiplication by 3 is xtime(a) ^ a.
    assign col_o[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign col_o[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign col_o[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign col_o[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/subword.sv
// Byte-wise S-box substitution of one 32-bit word.
module subword
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                     sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/cipher_rounds.sv
// Iterative AES-128 encryption, one round per clock, fed round keys by
// keyexpansion; reset doubles as the start strobe and captures plaintext.
module cipher_rounds
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] plaintext,
    input  logic [127:0] roundKey,
    output logic [127:0] ciphertext,
    output logic         done
);

    cipher_state_t fsm_q, fsm_d;
    logic [127:0]  state_q, state_d;
    logic [3:0]    round_q, round_d;
    logic          done_q, done_d;

    logic [127:0]  sb_state, sr_state, mc_state;

    // Column c occupies [127-32c -: 32]; byte s(r,c) is [127-8(4c+r) -: 8].
    for (genvar c = 0; c < 4; c++) begin : g_col
        subword u_subword (
            .word_i (state_q[127-32*c -: 32]),
            .word_o (sb_state[127-32*c -: 32])
        );

        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr_state[127-8*(4*c+r) -: 8] =
                sb_state[127-8*(4*((c+r)%4)+r) -: 8];
        end

        mixcolumn u_mixcolumn (
            .col_i (sr_state[127-32*c -: 32]),
            .col_o (mc_state[127-32*c -: 32])
        );
    end

    // NOTE: every always_comb output gets a hold default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        done_d  = done_q;
        case (fsm_q)
            ST_INIT: begin
                state_d = state_q ^ roundKey;
                round_d = 4'd1;
                fsm_d   = ST_ROUND;
            end
            ST_ROUND: begin
                state_d = mc_state ^ roundKey;
                round_d = round_q + 4'd1;
                if (round_q == 4'(NR - 1)) begin
                    fsm_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                state_d = sr_state ^ roundKey;
                fsm_d   = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
            end
            default: begin
                fsm_d  = ST_DONE;
                done_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= ST_INIT;
            state_q <= plaintext;
            round_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign ciphertext = state_q;
    assign done       = done_q;

endmodule

// File: tb/tb_cipher_rounds.sv
// Self-checking bench: cipher_rounds fed by keyexpansion, checked against a
// byte-level AES-128 reference model through a start-time scoreboard.
module tb_cipher_rounds;

    logic         clk;
    logic         reset;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic [127:0] round_key;
    logic [127:0] ciphertext;
    logic         done;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] e1;
        logic [127:0] ct;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    int   completed = 0;
    int   expected_done = 0;
    bit   active = 0;
    int   cnt = 0;

    logic [7:0] sbox_m [256];

    keyexpansion u_keyexp (
        .clk         (clk),
        .reset       (reset),
        .key_i       (key),
        .done_i      (done),
        .round_key_o (round_key)
    );

    cipher_rounds dut (
        .clk        (clk),
        .reset      (reset),
        .plaintext  (plaintext),
        .roundKey   (round_key),
        .ciphertext (ciphertext),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0]  y = 8'h00;
            logic [15:0] d;
            for (int c = 1; c < 256; c++) begin
                if (x != 0 && gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
            end
            d = {y, y};
            sbox_m[x] = y ^ d[14 -: 8] ^ d[13 -: 8] ^ d[12 -: 8] ^ d[11 -: 8] ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rcon = 8'h01;
        logic [31:0]  tw;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {tw[23:0], tw[31:24]};
                tw = {sbox_m[tw[31:24]], sbox_m[tw[23:16]], sbox_m[tw[15:8]], sbox_m[tw[7:0]]};
                tw = tw ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int rnd = 0; rnd <= 10; rnd++) begin
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) begin
                        if (rnd < 10)
                            s[4*c+r] = gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                                     ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
                        else
                            s[4*c+r] = t[4*c+r];
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus ----------------
    // All tasks assume the caller sits just after a falling edge.
    task automatic start(input logic [127:0] k, input logic [127:0] pt,
                         input logic [127:0] e1, input logic [127:0] ct);
        exp_t e;
        e.pt = pt;
        e.e1 = e1;
        e.ct = ct;
        sb_q.push_back(e);
        reset     = 1'b1;
        key       = k;
        plaintext = pt;
        @(negedge clk);
        reset     = 1'b0;
        plaintext = rand128();
    endtask

    task automatic wait_done(input int hold);
        int i = 0;
        expected_done++;
        while (!done && i < 40) begin
            @(negedge clk);
            plaintext = rand128();
            i++;
        end
        if (!done) check("done_timeout", {127'd0, done}, 128'd1);
        repeat (hold) begin
            @(negedge clk);
            plaintext = rand128();
        end
    endtask

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] E1_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        logic [127:0] rk, rp;
        reset     = 1'b0;
        key       = '0;
        plaintext = '0;
        build_sbox();
        @(negedge clk);

        start(KEY_B, PT_B, E1_B, CT_B);
        wait_done(20);
        start(KEY_C, PT_C, PT_C ^ KEY_C, CT_C);
        wait_done(2);
        start('0, '0, '0, CT_Z);
        wait_done(1);

        // Abort App. B after E5 and restart with App. C.1.
        start(KEY_B, PT_B, E1_B, CT_B);
        repeat (5) @(negedge clk);
        start(KEY_C, PT_C, PT_C ^ KEY_C, CT_C);
        wait_done(0);

        // Back-to-back: restart on the first cycle done is seen.
        start(KEY_B, PT_B, E1_B, CT_B);
        wait_done(0);
        start(KEY_B, PT_B, E1_B, CT_B);
        wait_done(0);

        for (int n = 0; n < 6; n++) begin
            rk = rand128();
            rp = rand128();
            start(rk, rp, rk ^ rp, aes_ref(rk, rp));
            wait_done(int'($urandom_range(0, 3)));
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
        check("runs_completed", 128'(completed), 128'(expected_done));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                check("scoreboard_entry", {127'd0, sb_q.size() > 0}, 128'd1);
                if (sb_q.size() > 0) begin
                    cur    = sb_q.pop_front();
                    active = 1'b1;
                    cnt    = 0;
                    check("reset_done", {127'd0, done}, 128'd0);
                    check("reset_state", ciphertext, cur.pt);
                end
            end else if (active) begin
                cnt++;
                if (cnt == 1) check("after_e1", ciphertext, cur.e1);
                if (cnt < 11) begin
                    check("early_done", {127'd0, done}, 128'd0);
                end else if (cnt == 11) begin
                    check("done_e11", {127'd0, done}, 128'd1);
                    check("ct_e11", ciphertext, cur.ct);
                    if (done) completed++;
                end else begin
                    check("hold_done", {127'd0, done}, 128'd1);
                    check("hold_ct", ciphertext, cur.ct);
                end
            end
        end
    end

endmodule
